// File: rtl/lsu_ram_master.sv
// ============================================================================
// lsu_ram_master : load/store initiator for a word-wide synchronous RAM,
//                  sub-word stores by read-modify-write. Option: LSU_BOUNDS_CHECK_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module lsu_ram_master #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       baddr,
    input  logic [DWIDTH-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DWIDTH-1:0] rdata,
    output logic              ramR,
    output logic              ramW,
    output logic [31:0]       addr,
    output logic [DWIDTH-1:0] dataW,
    input  logic [DWIDTH-1:0] dataR
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit c_BOUNDS_EN = 1'b1;
`else
    localparam bit c_BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;
    logic [15:0]       r_wdata;
    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_ramR;
    logic              r_ramW;
    logic [31:0]       r_addr;
    logic [DWIDTH-1:0] r_dataW;

    logic              w_is_half;
    logic              w_is_word;
    logic              w_bad_f3;
    logic              w_misal;
    logic              w_oob;
    logic              w_reject;
    logic [DWIDTH-1:0] w_lane_data;
    logic [DWIDTH-1:0] w_load_val;
    logic [DWIDTH-1:0] w_mask;
    logic [DWIDTH-1:0] w_ins;
    logic [DWIDTH-1:0] w_merged;

    // Request qualification, evaluated on the raw inputs in IDLE
    assign w_is_half = (funct3[1:0] == 2'b01);
    assign w_is_word = (funct3[1:0] == 2'b10);
    assign w_bad_f3  = we ? (funct3[2] || (funct3[1:0] == 2'b11))
                          : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    assign w_misal   = (w_is_half && baddr[0]) || (w_is_word && (baddr[1:0] != 2'b00));
    assign w_oob     = c_BOUNDS_EN && ((baddr >> (AWIDTH + 2)) != 32'd0);
    assign w_reject  = w_bad_f3 || w_misal || w_oob;

    // Lane handling on the captured word; lane logic assumes DWIDTH == 32
    assign w_lane_data = dataR >> {r_lane, 3'b000};

    always_comb begin
        w_load_val = dataR;
        case (r_funct3)
            3'b000:  w_load_val = {{(DWIDTH-8){w_lane_data[7]}}, w_lane_data[7:0]};
            3'b001:  w_load_val = {{(DWIDTH-16){w_lane_data[15]}}, w_lane_data[15:0]};
            3'b100:  w_load_val = {{(DWIDTH-8){1'b0}}, w_lane_data[7:0]};
            3'b101:  w_load_val = {{(DWIDTH-16){1'b0}}, w_lane_data[15:0]};
            default: w_load_val = dataR;
        endcase
    end

    always_comb begin
        if (r_funct3[1:0] == 2'b00) begin
            w_mask = {{(DWIDTH-8){1'b0}}, 8'hFF} << {r_lane, 3'b000};
            w_ins  = {{(DWIDTH-8){1'b0}}, r_wdata[7:0]} << {r_lane, 3'b000};
        end else begin
            w_mask = {{(DWIDTH-16){1'b0}}, 16'hFFFF} << {r_lane, 3'b000};
            w_ins  = {{(DWIDTH-16){1'b0}}, r_wdata} << {r_lane, 3'b000};
        end
        w_merged = (dataR & ~w_mask) | (w_ins & w_mask);
    end

    // All outputs are registered and set for the state being entered
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_lane   <= 2'b00;
            r_wdata  <= 16'h0000;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_ramR   <= 1'b0;
            r_ramW   <= 1'b0;
            r_addr   <= 32'd0;
            r_dataW  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we     <= we;
                        r_funct3 <= funct3;
                        r_lane   <= baddr[1:0];
                        r_wdata  <= wdata[15:0];
                        r_ready  <= 1'b0;
                        if (w_reject) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (we && w_is_word) begin
                            r_state <= S_WR;
                            r_ramW  <= 1'b1;
                            r_addr  <= {2'b00, baddr[31:2]};
                            r_dataW <= wdata;
                        end else begin
                            r_state <= S_RD;
                            r_ramR  <= 1'b1;
                            r_addr  <= {2'b00, baddr[31:2]};
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_CAP;
                    r_ramR  <= 1'b0;
                end
                S_CAP: begin
                    if (r_we) begin
                        r_state <= S_WR;
                        r_ramW  <= 1'b1;
                        r_dataW <= w_merged;
                    end else begin
                        r_state <= S_DONE;
                        r_rdata <= w_load_val;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                S_WR: begin
                    r_state <= S_DONE;
                    r_ramW  <= 1'b0;
                    r_done  <= 1'b1;
                    r_err   <= 1'b0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ramR  <= 1'b0;
                    r_ramW  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign err   = r_err;
    assign rdata = r_rdata;
    assign ramR  = r_ramR;
    assign ramW  = r_ramW;
    assign addr  = r_addr;
    assign dataW = r_dataW;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ram_master.sv
// ============================================================================
// tb_lsu_ram_master : directed + random load/store sequence against a
//                     word-level reference memory model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lsu_ram_master;

    localparam int AW = 5;

    logic        clock;
    logic        nReset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] baddr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        ramR;
    logic        ramW;
    logic [31:0] addr;
    logic [31:0] dataW;
    logic [31:0] dataR;

    logic [31:0] mem     [32];
    logic [31:0] ref_mem [32];
    logic [31:0] exp_rdata;
    int          rd_cnt;
    int          wr_cnt;
    int          checks;
    int          failures;

    lsu_ram_master #(.DWIDTH(32), .AWIDTH(AW)) dut (
        .clock  (clock),
        .nReset (nReset),
        .req    (req),
        .we     (we),
        .funct3 (funct3),
        .baddr  (baddr),
        .wdata  (wdata),
        .ready  (ready),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .ramR   (ramR),
        .ramW   (ramW),
        .addr   (addr),
        .dataW  (dataW),
        .dataR  (dataR)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM, one-cycle read latency
    always @(posedge clock) begin
        if (ramR) dataR <= mem[addr[AW-1:0]];
        if (ramW) mem[addr[AW-1:0]] <= dataW;
    end

    always @(posedge clock) begin
        if (ramR) rd_cnt++;
        if (ramW) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [31:0] w;
        w = word >> (8 * lane);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic ref_reject(input logic st, input logic [2:0] f3, input logic [31:0] ba);
        logic bad;
        int   size;
        bad  = st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        if (!bad && (ba % size) != 0) bad = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
        if ((ba >> (AW + 2)) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] ba,
                          input logic [31:0] wd);
        logic        rej;
        int          idx;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          lat;
        logic        got;
        logic        got_err;
        logic [31:0] mask;

        rej = ref_reject(st, f3, ba);
        idx = (ba >> 2) % 32;
        if (rej) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!st) begin
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
            exp_rdata = ref_extract(f3, ba[1:0], ref_mem[idx]);
        end else if (f3 == 3'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            ref_mem[idx] = wd;
        end else begin
            exp_lat = 4; exp_rd = 1; exp_wr = 1;
            mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * ba[1:0]);
            ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << (8 * ba[1:0])) & mask);
        end

        @(negedge clock);
        chk("ready_idle", {31'd0, ready}, 32'd1);
        rd_cnt = 0;
        wr_cnt = 0;
        req    = 1'b1;
        we     = st;
        funct3 = f3;
        baddr  = ba;
        wdata  = wd;
        @(posedge clock);
        #1;
        req    = 1'b0;
        baddr  = $urandom;
        wdata  = $urandom;
        lat    = 0;
        got    = 1'b0;
        got_err = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            lat++;
            if (done) begin
                got     = 1'b1;
                got_err = err;
                break;
            end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", lat, exp_lat);
        chk("err", {31'd0, got_err}, {31'd0, rej});
        chk("rdata", rdata, exp_rdata);
        chk("ram_reads", rd_cnt, exp_rd);
        chk("ram_writes", wr_cnt, exp_wr);
        chk("mem_word", mem[idx], ref_mem[idx]);
        @(negedge clock);
        chk("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] ba;
        checks    = 0;
        failures  = 0;
        exp_rdata = 32'd0;
        rd_cnt    = 0;
        wr_cnt    = 0;
        nReset    = 1'b0;
        req       = 1'b0;
        we        = 1'b0;
        funct3    = 3'd0;
        baddr     = 32'd0;
        wdata     = 32'd0;
        dataR     = 32'd0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clock);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_strobes", {30'd0, ramR, ramW}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_dataW", dataW, 32'd0);
        nReset = 1'b1;

        // Word store/load round trip
        access(1'b1, 3'd2, 32'h8, 32'hDEADBEEF);
        access(1'b0, 3'd2, 32'h8, 32'h0);
        chk("t1_lw", rdata, 32'hDEADBEEF);

        // Byte RMW and byte loads
        access(1'b1, 3'd0, 32'h9, 32'h55);
        chk("t2_word2", mem[2], 32'hDEAD55EF);
        access(1'b0, 3'd0, 32'h9, 32'h0);
        chk("t2_lb9", rdata, 32'h00000055);
        access(1'b0, 3'd0, 32'hB, 32'h0);
        chk("t2_lbB", rdata, 32'hFFFFFFDE);
        access(1'b0, 3'd4, 32'hB, 32'h0);
        chk("t2_lbuB", rdata, 32'h000000DE);

        // Half RMW and half loads
        access(1'b1, 3'd1, 32'hA, 32'h8001);
        access(1'b0, 3'd1, 32'hA, 32'h0);
        chk("t3_lh", rdata, 32'hFFFF8001);
        access(1'b0, 3'd5, 32'hA, 32'h0);
        chk("t3_lhu", rdata, 32'h00008001);
        chk("t3_word2", mem[2], 32'h800155EF);

        // Rejected accesses
        access(1'b0, 3'd2, 32'h6, 32'h0);
        access(1'b0, 3'd1, 32'h3, 32'h0);
        access(1'b1, 3'd4, 32'h4, 32'h0);
        chk("t4_rdata_held", rdata, 32'h00008001);

        // Reset during the capture phase of a byte store
        @(negedge clock);
        wr_cnt = 0;
        req    = 1'b1;
        we     = 1'b1;
        funct3 = 3'd0;
        baddr  = 32'h4;
        wdata  = 32'hAA;
        @(posedge clock);
        #1;
        req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        nReset = 1'b0;
        #1;
        exp_rdata = 32'd0;
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_flags", {29'd0, done, err, ramW}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_addr", addr, 32'd0);
        chk("mid_rst_dataW", dataW, 32'd0);
        repeat (2) @(negedge clock);
        nReset = 1'b1;
        repeat (2) @(negedge clock);
        chk("mid_rst_no_write", wr_cnt, 32'd0);
        chk("mid_rst_word1", mem[1], ref_mem[1]);

        // Out-of-range word access: alias or reject depending on build
        access(1'b0, 3'd2, 32'h80, 32'h0);

        // Random mix, including misaligned, bad funct3 and high address bits
        for (int n = 0; n < 80; n++) begin
            ba = $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) ba = ba | (32'h1 << $urandom_range(7, 31));
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ba, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
